// File: rtl/lcd_delay_timer_if.sv
// Bus between the LCD init sequencer (master) and the delay timer (slave).
//
// Handshake: the master pulses start for one cycle with delay_ticks/periodic
// valid in that same cycle; there is no ready, because the timer accepts a
// start in every cycle (a start while running is a retrigger). The timer
// answers with a one-cycle done pulse at each terminal count and holds busy
// high while a delay is in progress. abort may be pulsed at any time and
// cancels the run without a done.
interface lcd_delay_timer_if #(
  parameter int CNT_W = 30
);
  logic             start;
  logic [CNT_W-1:0] delay_ticks;
  logic             periodic;
  logic             abort;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ticks_left;
  logic             state_dbg;

  modport master (
    output start, delay_ticks, periodic, abort,
    input  busy, done, ticks_left, state_dbg
  );

  modport slave (
    input  start, delay_ticks, periodic, abort,
    output busy, done, ticks_left, state_dbg
  );
endinterface

// File: rtl/lcd_delay_timer.sv
// Prescaled start/done delay timer for LCD power-up and command waits.
// A prescaler turns PRE_DIV clock cycles into one tick; the tick counter
// counts a latched length N down to the terminal count, then either stops
// (one-shot) or reloads (periodic). state_dbg mirrors the FSM state.
module lcd_delay_timer #(
  parameter int CNT_W   = 30,
  parameter int PRE_DIV = 50
) (
  input  logic               clk,
  input  logic               rst,
  lcd_delay_timer_if.slave   bus
);

  // Prescaler needs at least one bit even when PRE_DIV = 1 (no prescaling).
  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRE_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]   ticks_q, ticks_d;
  logic [CNT_W-1:0]   n_lat_q, n_lat_d;
  logic               per_lat_q, per_lat_d;
  logic               done_q, done_d;

  logic               wrap;
  logic               term_cnt;
  logic [CNT_W-1:0]   n_eff;

  // A zero length would never reach terminal count, so it runs as one tick.
  assign n_eff    = (bus.delay_ticks == '0) ? CNT_W'(1) : bus.delay_ticks;
  assign wrap     = (pre_cnt_q == PRE_MAX);
  assign term_cnt = (state_q == RUN) && wrap && (ticks_q == CNT_W'(1));

  // Next-state logic: abort beats start, start beats counting.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    ticks_d   = ticks_q;
    n_lat_d   = n_lat_q;
    per_lat_d = per_lat_q;
    done_d    = 1'b0;

    if (bus.abort) begin
      // Cancels even a coinciding terminal count: no done is issued.
      state_d   = IDLE;
      ticks_d   = '0;
      pre_cnt_d = '0;
    end else if (bus.start) begin
      // Retrigger keeps the done of a run that ends in this very cycle.
      done_d    = term_cnt;
      state_d   = RUN;
      n_lat_d   = n_eff;
      ticks_d   = n_eff;
      per_lat_d = bus.periodic;
      pre_cnt_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (wrap) begin
            pre_cnt_d = '0;
            if (term_cnt) begin
              done_d = 1'b1;
              if (per_lat_q) begin
                ticks_d = n_lat_q;
              end else begin
                ticks_d = '0;
                state_d = IDLE;
              end
            end else if (ticks_q != '0) begin
              ticks_d = ticks_q - CNT_W'(1);
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end
        default: begin
          // IDLE holds the counter at zero until the next start.
          ticks_d   = '0;
          pre_cnt_d = '0;
        end
      endcase
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      ticks_q   <= '0;
      n_lat_q   <= '0;
      per_lat_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      ticks_q   <= ticks_d;
      n_lat_q   <= n_lat_d;
      per_lat_q <= per_lat_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.ticks_left = ticks_q;
  assign bus.state_dbg  = state_q;

endmodule
